// File: rtl/axis_pkt_gen.sv
// axis_pkt_gen: AXI-Stream packet generator.
//   On start, emits cfg_npkt packets (0 = until stop) of max(cfg_len,1) beats,
//   separated by cfg_gap idle cycles, with tdata incrementing from cfg_seed.
// Ports:
//   clk, rst (async, active-high)
//   start, stop                 run control (start accepted in IDLE only)
//   cfg_len/npkt/gap/seed       run configuration, latched on start
//   busy, done, pkt_count       run status
//   m_axis_tdata/tvalid/tlast   master stream outputs (registered)
//   m_axis_tready               downstream ready
module axis_pkt_gen #(
  parameter int unsigned c_WIDTH = 8,
  parameter int unsigned c_LEN_W = 16,
  parameter int unsigned c_GAP_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [c_LEN_W-1:0] cfg_len,
  input  logic [15:0]        cfg_npkt,
  input  logic [c_GAP_W-1:0] cfg_gap,
  input  logic [c_WIDTH-1:0] cfg_seed,
  output logic               busy,
  output logic               done,
  output logic [15:0]        pkt_count,
  output logic [c_WIDTH-1:0] m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  state_t             state;
  logic [c_LEN_W-1:0] len_r;
  logic [15:0]        npkt_r;
  logic [c_GAP_W-1:0] gap_r;
  logic [c_GAP_W-1:0] gap_cnt;
  logic [c_LEN_W-1:0] beat;
  logic               stop_pend;

  logic [15:0]        cnt_inc;
  logic               stop_seen;
  logic               run_end;

  always_comb begin
    cnt_inc   = (pkt_count == '1) ? pkt_count : pkt_count + 16'd1;
    // A stop raised in the same cycle as the deciding handshake also counts.
    stop_seen = stop_pend | stop;
    run_end   = ((npkt_r != '0) && (cnt_inc == npkt_r)) || stop_seen;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      len_r         <= '0;
      npkt_r        <= '0;
      gap_r         <= '0;
      gap_cnt       <= '0;
      beat          <= '0;
      stop_pend     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pkt_count     <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            len_r         <= (cfg_len == '0) ? c_LEN_W'(1) : cfg_len;
            npkt_r        <= cfg_npkt;
            gap_r         <= cfg_gap;
            pkt_count     <= '0;
            m_axis_tdata  <= cfg_seed;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= (cfg_len <= c_LEN_W'(1));
            beat          <= c_LEN_W'(1);
            busy          <= 1'b1;
            stop_pend     <= 1'b0;
            state         <= S_SEND;
          end
        end

        S_SEND: begin
          if (stop) stop_pend <= 1'b1;
          if (m_axis_tready) begin
            m_axis_tdata <= m_axis_tdata + c_WIDTH'(1);
            if (m_axis_tlast) begin
              pkt_count <= cnt_inc;
              if (run_end) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
                busy          <= 1'b0;
                done          <= 1'b1;
                state         <= S_DONE;
              end else if (gap_r != '0) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
                gap_cnt       <= gap_r;
                state         <= S_GAP;
              end else begin
                beat         <= c_LEN_W'(1);
                m_axis_tlast <= (len_r == c_LEN_W'(1));
              end
            end else begin
              // beat < len_r here, so beat+1 cannot wrap even for the max length.
              beat         <= beat + c_LEN_W'(1);
              m_axis_tlast <= ((beat + c_LEN_W'(1)) == len_r);
            end
          end
        end

        S_GAP: begin
          if (stop) stop_pend <= 1'b1;
          if (stop_seen) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else if (gap_cnt == c_GAP_W'(1)) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= (len_r == c_LEN_W'(1));
            beat          <= c_LEN_W'(1);
            state         <= S_SEND;
          end else begin
            gap_cnt <= gap_cnt - c_GAP_W'(1);
          end
        end

        S_DONE: begin
          stop_pend <= 1'b0;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Self-checking bench for axis_pkt_gen: directed vector table, randomized
// runs and hand-written corner sequences against a run-level reference model.
module tb_axis_pkt_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [15:0] cfg_len;
  logic [15:0] cfg_npkt;
  logic [7:0]  cfg_gap;
  logic [7:0]  cfg_seed;
  logic        busy;
  logic        done;
  logic [15:0] pkt_count;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;

  int unsigned checks = 0;
  int unsigned errors = 0;

  axis_pkt_gen #(.c_WIDTH(8), .c_LEN_W(16), .c_GAP_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stop          (stop),
    .cfg_len       (cfg_len),
    .cfg_npkt      (cfg_npkt),
    .cfg_gap       (cfg_gap),
    .cfg_seed      (cfg_seed),
    .busy          (busy),
    .done          (done),
    .pkt_count     (pkt_count),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] len;
    logic [15:0] npkt;
    logic [7:0]  gap;
    logic [7:0]  seed;
    int unsigned stall_pct;
    int unsigned stop_pkt;      // stop raised during this packet (0 = never)
    bit          stop_at_start; // stop asserted together with start
    bit          inject;        // start pulse with new cfg while busy
    int unsigned exp_beats;
    logic [15:0] exp_pkts;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: number of packets a run produces.
  function automatic int unsigned model_npkts(input vec_t v);
    if (v.npkt == 0) return v.stop_pkt;
    if (v.stop_pkt != 0 && v.stop_pkt < v.npkt) return v.stop_pkt;
    return v.npkt;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    beat_t       expq[$];
    beat_t       got[$];
    int unsigned idles[$];
    int unsigned leff, n, cyc, last_hs, done_cyc, idle, nbeats;
    bit          measuring, done_seen, stop_fired, inj_fired;
    bit          prev_v, prev_r, prev_l;
    logic [7:0]  prev_d;
    logic [15:0] pc_done;
    logic        busy_done, tv_done;
    beat_t       b;

    leff = (v.len == 0) ? 1 : int'(v.len);
    n    = model_npkts(v);
    for (int unsigned i = 0; i < n * leff; i++) begin
      b.data = v.seed + 8'(i);
      b.last = ((i % leff) == leff - 1);
      expq.push_back(b);
    end

    @(negedge clk);
    cfg_len  = v.len;
    cfg_npkt = v.npkt;
    cfg_gap  = v.gap;
    cfg_seed = v.seed;
    start    = 1'b1;
    stop     = v.stop_at_start;
    m_axis_tready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    chk({tag, " busy_after_start"}, busy, 1'b1);
    chk({tag, " first_tdata"}, m_axis_tdata, v.seed);

    cyc = 0; last_hs = 0; done_cyc = 0; idle = 0; nbeats = 0;
    measuring = 0; done_seen = 0; stop_fired = 0; inj_fired = 0;
    prev_v = 0; prev_r = 0; prev_l = 0; prev_d = '0;
    pc_done = '0; busy_done = 1'b1; tv_done = 1'b1;

    while (cyc < 3000) begin
      if (prev_v && !prev_r) begin
        chk({tag, " hold_tvalid"}, m_axis_tvalid, 1'b1);
        chk({tag, " hold_tdata"}, m_axis_tdata, prev_d);
        chk({tag, " hold_tlast"}, m_axis_tlast, prev_l);
      end
      if (done) begin
        done_seen = 1;
        done_cyc  = cyc;
        pc_done   = pkt_count;
        busy_done = busy;
        tv_done   = m_axis_tvalid;
        break;
      end
      if (measuring) begin
        if (m_axis_tvalid) begin
          idles.push_back(idle);
          measuring = 0;
        end else begin
          idle++;
        end
      end

      start = 1'b0;
      stop  = 1'b0;
      m_axis_tready = ($urandom_range(99) >= v.stall_pct);
      if (m_axis_tvalid && m_axis_tready) begin
        b.data = m_axis_tdata;
        b.last = m_axis_tlast;
        got.push_back(b);
        nbeats++;
        last_hs = cyc;
        if (m_axis_tlast) begin
          measuring = 1;
          idle = 0;
        end
        if (v.stop_pkt != 0 && !stop_fired && nbeats == (v.stop_pkt - 1) * leff + 1) begin
          stop = 1'b1;
          stop_fired = 1;
        end
      end
      if (v.inject && !inj_fired && nbeats == 2) begin
        start    = 1'b1;
        cfg_seed = ~v.seed;
        cfg_len  = 16'd9;
        cfg_npkt = 16'd1;
        cfg_gap  = 8'd7;
        inj_fired = 1;
      end
      prev_v = m_axis_tvalid;
      prev_r = m_axis_tready;
      prev_d = m_axis_tdata;
      prev_l = m_axis_tlast;
      @(negedge clk);
      cyc++;
    end

    if (!done_seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no done after %0d cycles, beats %0d", tag, cyc, nbeats);
      return;
    end

    chk({tag, " beat_count"}, got.size(), v.exp_beats);
    for (int unsigned i = 0; i < expq.size() && i < got.size(); i++) begin
      chk($sformatf("%s tdata[%0d]", tag, i), got[i].data, expq[i].data);
      chk($sformatf("%s tlast[%0d]", tag, i), got[i].last, expq[i].last);
    end
    chk({tag, " pkt_count"}, pc_done, v.exp_pkts);
    chk({tag, " done_latency"}, done_cyc, last_hs + 1);
    chk({tag, " busy_at_done"}, busy_done, 1'b0);
    chk({tag, " tvalid_at_done"}, tv_done, 1'b0);
    chk({tag, " gap_count"}, idles.size(), (n > 0) ? n - 1 : 0);
    foreach (idles[i]) chk($sformatf("%s gap[%0d]", tag, i), idles[i], v.gap);

    // start presented in the DONE cycle must be ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " done_start_busy"}, busy, 1'b0);
    chk({tag, " done_pulse_width"}, done, 1'b0);
    @(negedge clk);
    chk({tag, " done_start_busy2"}, busy, 1'b0);
    chk({tag, " done_start_tvalid"}, m_axis_tvalid, 1'b0);
    chk({tag, " idle_pkt_count"}, pkt_count, v.exp_pkts);
  endtask

  vec_t vecs[9];

  initial begin
    vec_t rv;

    //        len    npkt   gap   seed   stall stop sas inj beats pkts
    vecs[0] = '{16'd4, 16'd2, 8'd0, 8'hFE, 0,  0, 0, 0, 8,  16'd2};
    vecs[1] = '{16'd3, 16'd2, 8'd2, 8'h10, 0,  0, 0, 0, 6,  16'd2};
    vecs[2] = '{16'd4, 16'd2, 8'd0, 8'hFE, 50, 0, 0, 0, 8,  16'd2};
    vecs[3] = '{16'd5, 16'd0, 8'd0, 8'h40, 0,  2, 0, 0, 10, 16'd2};
    vecs[4] = '{16'd0, 16'd5, 8'd0, 8'h80, 0,  0, 0, 1, 5,  16'd5};
    vecs[5] = '{16'd2, 16'd3, 8'd3, 8'hF0, 30, 0, 0, 0, 6,  16'd3};
    vecs[6] = '{16'd1, 16'd4, 8'd1, 8'h7F, 50, 0, 0, 0, 4,  16'd4};
    vecs[7] = '{16'd5, 16'd0, 8'd4, 8'h00, 40, 3, 0, 0, 15, 16'd3};
    vecs[8] = '{16'd2, 16'd2, 8'd1, 8'h33, 0,  0, 1, 0, 4,  16'd2};

    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    cfg_len = '0;
    cfg_npkt = '0;
    cfg_gap = '0;
    cfg_seed = '0;
    m_axis_tready = 1'b1;

    #12;
    chk("reset tvalid", m_axis_tvalid, 1'b0);
    chk("reset tlast", m_axis_tlast, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset tdata", m_axis_tdata, 8'h00);
    chk("reset pkt_count", pkt_count, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    for (int r = 0; r < 8; r++) begin
      rv.len           = 16'($urandom_range(7));
      rv.npkt          = 16'($urandom_range(1, 4));
      rv.gap           = 8'($urandom_range(3));
      rv.seed          = 8'($urandom);
      rv.stall_pct     = $urandom_range(60);
      rv.stop_pkt      = 0;
      rv.stop_at_start = 0;
      rv.inject        = 0;
      if (r % 3 == 0) begin
        rv.npkt     = 16'd0;
        rv.len      = 16'($urandom_range(2, 7));
        rv.stop_pkt = $urandom_range(1, 3);
      end
      rv.exp_beats = model_npkts(rv) * ((rv.len == 0) ? 1 : int'(rv.len));
      rv.exp_pkts  = 16'(model_npkts(rv));
      run_vec(rv, $sformatf("rand%0d", r));
    end

    // Asynchronous reset in the middle of a packet.
    @(negedge clk);
    cfg_len  = 16'd6;
    cfg_npkt = 16'd3;
    cfg_gap  = 8'd0;
    cfg_seed = 8'hA5;
    m_axis_tready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pre tvalid", m_axis_tvalid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid tvalid", m_axis_tvalid, 1'b0);
    chk("rst_mid tlast", m_axis_tlast, 1'b0);
    chk("rst_mid busy", busy, 1'b0);
    chk("rst_mid done", done, 1'b0);
    chk("rst_mid tdata", m_axis_tdata, 8'h00);
    chk("rst_mid pkt_count", pkt_count, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    rv = '{16'd3, 16'd1, 8'd0, 8'h11, 0, 0, 0, 0, 3, 16'd1};
    run_vec(rv, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
